wb_port_arbiter: RTL
====================

Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port among five result producers: 0=ALU, 1=LSU load, 2=MUL, 3=DIV, 4=CSR.
- Each producer uses a valid/ready handshake. The block grants at most one per cycle using rotating priority.
- It registers the winner's rd/data into a writeback stage.
- It emits the 3-bit select code that drives the 5:1 result mux, using encoding 0..4 = A0..A4.

Parameters:
- XLEN, riscv_pkg::XLEN (32): data width.
- NREQ, 5: requester count. Fixed; the block is not required to support other values.
- RW, 5: register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester result valid.
- req_rd  in  NREQ*RW  flattened destination regs; requester i uses bits [i*RW +: RW].
- req_data  in  NREQ*XLEN  flattened results; requester i uses bits [i*XLEN +: XLEN].
- req_ready  out  NREQ  one-hot-or-zero grant, combinational, same cycle.
- wb_stall  in  1  write port unavailable this cycle (debug or regfile busy).
- wb_we  out  1  registered write enable.
- wb_rd  out  RW  registered destination.
- wb_data  out  XLEN  registered write data.
- wb_sel  out  3  registered mux select of the last grant (0..4).
- busy_cnt  out  3  registered count of requesters currently waiting (valid && !ready).

Behaviour:
- Reset is synchronous, rst_n=0 at a clk edge:
  - wb_we=0, wb_rd=0, wb_data=0, wb_sel=3'b000, busy_cnt=0.
  - Round-robin pointer rr_ptr=0, so the ALU has top priority after reset.
- Arbitration (combinational):
  - If wb_stall=1, req_ready=0.
  - Otherwise the winner is the first i with req_valid[i]=1, scanning i = rr_ptr, rr_ptr+1, ... modulo 5. Wrap is 4 -> 0; values 5..7 are never reached.
  - req_ready has exactly the winner's bit set, or is 0 if no requester is valid.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester must hold valid, rd and data stable until it sees ready. Dropping valid without a grant is legal: the request is simply withdrawn.
- Pointer update:
  - On a transfer from requester i, rr_ptr <= (i==4) ? 0 : i+1.
  - With no transfer, or while stalled, rr_ptr holds.
- Writeback register, latency 1:
  - On the edge after a transfer from i: wb_rd=req_rd[i], wb_data=req_data[i], wb_sel=i.
  - wb_we=1 only if req_rd[i]!=0. A write to x0 is still granted and consumed, but wb_we=0.
  - With no transfer: wb_we=0 next cycle; wb_rd, wb_data and wb_sel hold their previous values.
- busy_cnt: registered popcount of (req_valid & ~req_ready), 0..5.
- Stall:
  - wb_stall=1 blocks all grants. Pending requesters keep waiting and no request is lost.
  - A stall asserted in the same cycle as a would-be grant wins; the grant does not occur.
- Reset mid-operation: any in-flight writeback register contents are discarded (wb_we=0 next cycle). Requesters re-present their results after reset.
- Single requester continuously valid: granted every cycle, giving 1 write/cycle throughput.
- Fairness: any continuously valid requester is granted within 5 grant cycles.

Test Plan:
- Reset, then req_valid=5'b00001, rd=3, data=32'hA5A5_0001:
  - req_ready=5'b00001 in the same cycle.
  - Next cycle: wb_we=1, wb_rd=3, wb_data=32'hA5A5_0001, wb_sel=0.
- All five valid continuously with distinct rd 1..5:
  - Grants in order 0,1,2,3,4,0.
  - wb_sel sequence is 0,1,2,3,4,0, one cycle behind.
  - busy_cnt=4 each cycle after the first.
- rr_ptr=4 via a prior grant to requester 3, then valid=5'b10001:
  - Requester 4 is granted first, then requester 0; wrap is verified.
- Requester 2 valid with rd=0, data=32'hDEAD_BEEF:
  - req_ready[2]=1.
  - Next cycle: wb_we=0, wb_sel=2, wb_data=32'hDEAD_BEEF.
- wb_stall=1 for 3 cycles with valid=5'b00110:
  - req_ready=0 and wb_we=0 throughout; busy_cnt=2.
  - After the stall drops: requester 1 is granted, then requester 2.
- rst_n=0 in the cycle after a grant:
  - wb_we=0, busy_cnt=0 and rr_ptr=0 after the reset edge.
  - The next request from requester 3 alongside requester 0 gives the grant to 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port among five result producers
// (0=ALU, 1=LSU load, 2=MUL, 3=DIV, 4=CSR) using rotating priority.
// The winner's destination and data are registered into a writeback stage,
// together with the 3-bit result-mux select code of the granted producer.

module wb_port_arbiter #(
    parameter int XLEN = 32,
    parameter int NREQ = 5,
    parameter int RW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*RW-1:0]   req_rd,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 wb_stall,
    output logic                 wb_we,
    output logic [RW-1:0]        wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic [2:0]           wb_sel,
    output logic [2:0]           busy_cnt
);

    // Requester whose turn it is to be scanned first (always 0..4).
    logic [2:0]      rr_ptr;

    logic [3:0]      scan_sum;
    logic            found;
    logic [2:0]      grant_idx;
    logic [NREQ-1:0] grant_vec;
    logic            transfer;
    logic [RW-1:0]   sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [NREQ-1:0] waiting;
    logic [2:0]      waiting_cnt;

    // Rotating-priority scan: first valid requester starting at rr_ptr, wrapping 4 -> 0.
    always_comb begin
        scan_sum  = 4'd0;
        found     = 1'b0;
        grant_idx = 3'd0;
        grant_vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + 4'(k);
            if (scan_sum >= 4'(NREQ)) begin
                scan_sum = scan_sum - 4'(NREQ);
            end
            if (!found && req_valid[scan_sum[2:0]]) begin
                found                     = 1'b1;
                grant_idx                 = scan_sum[2:0];
                grant_vec[scan_sum[2:0]]  = 1'b1;
            end
        end
    end

    // A stalled write port suppresses every grant, so no producer is consumed.
    always_comb begin
        req_ready = wb_stall ? '0 : grant_vec;
        transfer  = found && !wb_stall;
        sel_rd    = req_rd[grant_idx*RW +: RW];
        sel_data  = req_data[grant_idx*XLEN +: XLEN];
    end

    // Count producers that are presenting a result but were not granted this cycle.
    always_comb begin
        waiting     = req_valid & ~req_ready;
        waiting_cnt = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            waiting_cnt = waiting_cnt + {2'b00, waiting[i]};
        end
    end

    // Priority pointer moves just past the producer that actually transferred.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 3'd0;
        end else if (transfer) begin
            rr_ptr <= (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    // Writeback stage: capture the winner; x0 destinations are consumed without a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_we    <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_sel   <= 3'd0;
            busy_cnt <= 3'd0;
        end else begin
            busy_cnt <= waiting_cnt;
            if (transfer) begin
                wb_we   <= (sel_rd != '0);
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
                wb_sel  <= grant_idx;
            end else begin
                wb_we   <= 1'b0;
            end
        end
    end

endmodule
